load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the single-cycle datapath. Consumes the datapath's ALU result as the effective address and its register-file read port B as store data. Turns each load or store into a request/grant/response transaction on the data bus, and returns the formatted load word to the datapath's `read_data` input. While an access is outstanding it asserts `stall`, which the core uses to hold the PC register and suppress `reg_write`.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles spent in REQ+WAIT_R before the access is aborted; legal range 1..1023.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_read` in 1: current instruction is a load.
- `mem_write` in 1: current instruction is a store; wins if both `mem_read` and `mem_write` are high.
- `mem_size` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `mem_unsigned` in 1: zero-extend loads when high, sign-extend when low.
- `addr` in 32: effective byte address, taken from the datapath's ALU output.
- `write_data` in 32: store data.
- `read_data` out 32: formatted load result, registered.
- `stall` out 1: core must not advance.
- `misalign` out 1: one-cycle pulse on a misaligned or illegal-size access.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bus_req` out 1: request to the bus.
- `bus_we` out 1: write enable for the request.
- `bus_addr` out 32: request address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables.
- `bus_gnt` in 1: grant for the current request.
- `bus_rvalid` in 1: read response valid.
- `bus_rdata` in 32: read response data.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - Access = `mem_read|mem_write`.
  - Aligned access: latch address, byte enables, write data, direction, size and sign mode; go to REQ. `stall`=1 combinationally in this cycle.
  - Misaligned access: pulse `misalign`, no bus activity, `stall`=0; `read_data` is forced to 0 on the next edge.
- Alignment rules: half requires `addr[0]`=0; word requires `addr[1:0]`=0; size 11 is always misaligned.
- REQ: `bus_req`=1 with stable latched address, data and enables until `bus_gnt`.
  - Write and gnt: go to DONE.
  - Read, gnt and `bus_rvalid` in the same cycle: capture data, go to DONE.
  - Read and gnt only: go to WAIT_R.
- WAIT_R: `bus_req`=0; on `bus_rvalid`, capture formatted data into `read_data` and go to DONE. `bus_rvalid` seen in IDLE, DONE or REQ-without-gnt is ignored.
- DONE: `stall`=0 for exactly one cycle; the core retires the instruction on this edge. Next state is IDLE unconditionally, so the same instruction is never re-issued.
- Timeout: a counter clears on IDLE→REQ and increments each cycle in REQ or WAIT_R. On reaching `TIMEOUT`: pulse `bus_err`, drop `bus_req`, set `read_data`=0, go to DONE.
- Byte lanes (little-endian, o = `addr[1:0]`):
  - Byte: `bus_be`=0001<<o; `bus_wdata`={4{wd[7:0]}}.
  - Half: `bus_be`=0011<<o; `bus_wdata`={2{wd[15:0]}}.
  - Word: `bus_be`=1111; `bus_wdata`=wd.
- Load formatting: select the lane at offset o, then sign- or zero-extend per `mem_unsigned` to 32 bits.

## Timing
- Reset (edge with `reset`=1): state IDLE, counter 0, `read_data`=0. All other outputs are 0 after the edge. An in-flight transaction is abandoned and `bus_req` drops; a late `bus_rvalid` is ignored.
- `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `bus_err` and `read_data` are driven from registers or state only.
- `stall` and `misalign` are combinational from state and the IDLE-cycle inputs.
- Minimum latency is 3 cycles (IDLE, REQ, DONE), for a write, or for a read with gnt and rvalid together.
- Each extra cycle before gnt or before rvalid adds one cycle.
- Worst case is `TIMEOUT`+2 cycles.

## Structure
- Package `lsu_pkg`: state enum `lsu_state_t`; size constants `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10.
- One sub-module, `load_align`: combinational lane select and extension, taking `bus_rdata`, o, size and `mem_unsigned` and returning 32 bits.
- Byte-enable and store-replication logic stays inline.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, gnt in first REQ cycle → `bus_be`=1111, `bus_addr`=0x100, `stall` high for 2 cycles, DONE on cycle 3.
- Byte load, addr 0x103, signed, `bus_rdata`=0x80000000, rvalid 2 cycles after gnt → `read_data`=0xFFFFFF80; same with `mem_unsigned`=1 → 0x00000080.
- Half store, addr 0x202, data 0x0000A5A5 → `bus_be`=1100, `bus_wdata`=0xA5A5A5A5.
- Half load at 0x201 → `misalign` pulse, no `bus_req`, `stall`=0, `read_data`=0.
- Read, gnt never asserted, `TIMEOUT`=4 → `bus_err` pulse after 4 REQ cycles, `bus_req` drops, `read_data`=0, DONE next.
- `reset` asserted in WAIT_R with rvalid arriving the following cycle → IDLE, all outputs 0, rvalid ignored; a subsequent load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by the top level and by the load alignment block.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        unique case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane selection and sign/zero extension.
// Purely combinational; fed by the raw bus read data.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_b;
    logic [15:0] w_h;
    logic        w_sb;
    logic        w_sh;

    always_comb begin
        w_b = 8'h00;
        unique case (i_off)
            2'd0: w_b = i_rdata[7:0];
            2'd1: w_b = i_rdata[15:8];
            2'd2: w_b = i_rdata[23:16];
            2'd3: w_b = i_rdata[31:24];
            default: w_b = 8'h00;
        endcase
        w_h  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_sb = ~i_unsigned & w_b[7];
        w_sh = ~i_unsigned & w_h[15];
        case (i_size)
            SZ_BYTE: o_data = {{24{w_sb}}, w_b};
            SZ_HALF: o_data = {{16{w_sh}}, w_h};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns loads/stores into req/gnt/rvalid
// bus transactions and stalls the core while one is in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic        r_unsigned;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [9:0]  r_cnt;

    logic        w_access;
    logic        w_aligned;
    logic        w_start;
    logic        w_cap;
    logic        w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    load_align u_align (
        .i_rdata    (i_bus_rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ldata)
    );

    always_comb begin
        w_access  = i_mem_read | i_mem_write;
        w_aligned = is_aligned(i_mem_size, i_addr[1:0]);
        w_be      = 4'b1111;
        w_wdata   = i_write_data;
        case (i_mem_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_write_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << i_addr[1:0];
                w_wdata = {2{i_write_data[15:0]}};
            end
            default: ;
        endcase
    end

    // A completing grant/rvalid beats the timeout in the same cycle.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_cap      = 1'b0;
        w_tmo      = 1'b0;
        o_stall    = 1'b0;
        o_misalign = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_start = 1'b1;
                        o_stall = 1'b1;
                        w_next  = S_REQ;
                    end else begin
                        o_misalign = 1'b1;
                    end
                end
            end
            S_REQ: begin
                o_stall = 1'b1;
                if (i_bus_gnt && (r_we || i_bus_rvalid)) begin
                    w_cap  = ~r_we;
                    w_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = S_DONE;
                end else if (i_bus_gnt) begin
                    w_next = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                o_stall = 1'b1;
                if (i_bus_rvalid) begin
                    w_cap  = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
        end else begin
            r_err <= w_tmo;
            if (w_start) begin
                r_addr     <= {i_addr[31:2], 2'b00};
                r_off      <= i_addr[1:0];
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_we       <= i_mem_write;
                r_size     <= i_mem_size;
                r_unsigned <= i_mem_unsigned;
                r_cnt      <= '0;
            end else if (r_state == S_REQ || r_state == S_WAIT_R) begin
                r_cnt <= r_cnt + 10'd1;
            end
            if (w_cap) begin
                r_rdata <= w_ldata;
            end else if (w_tmo || o_misalign) begin
                r_rdata <= '0;
            end
        end
    end

    assign o_bus_req   = (r_state == S_REQ);
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_be    = r_be;
    assign o_bus_err   = r_err;
    assign o_read_data = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push
// expectations, a negedge monitor pops them on bus/retire events.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_mem_size     (mem_size),
        .i_mem_unsigned (mem_unsigned),
        .i_addr         (addr),
        .i_write_data   (write_data),
        .o_read_data    (read_data),
        .o_stall        (stall),
        .o_misalign     (misalign),
        .o_bus_err      (bus_err),
        .o_bus_req      (bus_req),
        .o_bus_we       (bus_we),
        .o_bus_addr     (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .o_bus_be       (bus_be),
        .i_bus_gnt      (bus_gnt),
        .i_bus_rvalid   (bus_rvalid),
        .i_bus_rdata    (bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct {
        logic        misal;
        logic        chk_rd;
        logic [31:0] rd;
        logic        err;
        int          stl;
    } rsp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        int          gd;
        int          rv;
        logic        ng;
        logic [31:0] rdat;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_mis;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_stl;
    } vec_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    logic m_prev = 1'b0;
    int   m_stl = 0;
    logic m_chkz = 1'b0;

    initial begin : monitor
        req_t r;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_prev = 1'b0;
                m_stl  = 0;
                m_chkz = 1'b0;
            end else begin
                if (m_chkz) begin
                    chk("misalign_rd_zero", read_data, 32'h0);
                    m_chkz = 1'b0;
                end
                if (bus_req && bus_gnt) begin
                    if (req_q.size() == 0) bad("unexpected_req");
                    else begin
                        r = req_q.pop_front();
                        chk("bus_addr", bus_addr, r.addr);
                        chk("bus_be", {28'h0, bus_be}, {28'h0, r.be});
                        chk("bus_wdata", bus_wdata, r.wdata);
                        chk("bus_we", {31'h0, bus_we}, {31'h0, r.we});
                    end
                end
                if (misalign) begin
                    if (rsp_q.size() == 0) bad("unexpected_misalign");
                    else begin
                        e = rsp_q.pop_front();
                        chk("misalign_expected", 32'h1, {31'h0, e.misal});
                        chk("misalign_stall", {31'h0, stall}, 32'h0);
                        chk("misalign_req", {31'h0, bus_req}, 32'h0);
                        m_chkz = 1'b1;
                    end
                end
                if (m_prev && !stall) begin
                    if (rsp_q.size() == 0) bad("unexpected_retire");
                    else begin
                        e = rsp_q.pop_front();
                        chk("retire_not_misal", {31'h0, e.misal}, 32'h0);
                        chk("stall_cycles", m_stl, e.stl);
                        chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
                        chk("req_dropped", {31'h0, bus_req}, 32'h0);
                        if (e.chk_rd) chk("read_data", read_data, e.rd);
                    end
                    m_stl = 0;
                end else if (bus_err) begin
                    bad("stray_bus_err");
                end
                if (stall) m_stl++;
                m_prev = stall;
            end
        end
    end

    task automatic zero_outputs(input string tag);
        chk({tag, "_read_data"}, read_data, 32'h0);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        chk({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
        chk({tag, "_bus_req"}, {31'h0, bus_req}, 32'h0);
        chk({tag, "_bus_we"}, {31'h0, bus_we}, 32'h0);
        chk({tag, "_bus_addr"}, bus_addr, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_bus_be"}, {28'h0, bus_be}, 32'h0);
    endtask

    task automatic run(input vec_t v);
        req_t r;
        rsp_t e;
        @(posedge clk);
        #1;
        mem_read     = v.rd;
        mem_write    = v.wr;
        mem_size     = v.sz;
        mem_unsigned = v.uns;
        addr         = v.a;
        write_data   = v.wd;
        if (!v.e_mis && !v.ng) begin
            r.addr  = v.e_addr;
            r.be    = v.e_be;
            r.wdata = v.e_wd;
            r.we    = v.wr;
            req_q.push_back(r);
        end
        e.misal  = v.e_mis;
        e.chk_rd = v.rd & ~v.wr & ~v.e_mis;
        e.rd     = v.e_rd;
        e.err    = v.e_err;
        e.stl    = v.e_stl;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!v.e_mis && !v.ng) begin
            repeat (v.gd) begin
                @(posedge clk);
                #1;
            end
            bus_gnt = 1'b1;
            if (v.rd && !v.wr && v.rv == 0) begin
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdat;
            end
            @(posedge clk);
            #1;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (v.rd && !v.wr && v.rv > 0) begin
                repeat (v.rv - 1) begin
                    @(posedge clk);
                    #1;
                end
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdat;
                @(posedge clk);
                #1;
                bus_rvalid = 1'b0;
            end
        end
        repeat (TMO + 4) @(posedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        vec_t v;
        req_t r;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        zero_outputs("reset");

        v = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0,
              32'h100, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2};
        run(v);
        v = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 0, 2, 1'b0, 32'h80000000,
              32'h100, 4'b1000, 32'h0, 1'b0, 1'b0, 32'hFFFFFF80, 4};
        run(v);
        v = '{1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 0, 2, 1'b0, 32'h80000000,
              32'h100, 4'b1000, 32'h0, 1'b0, 1'b0, 32'h00000080, 4};
        run(v);
        v = '{1'b0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000A5A5, 1, 0, 1'b0, 32'h0,
              32'h200, 4'b1100, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 3};
        run(v);
        v = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h201, 32'h0, 0, 0, 1'b0, 32'h0,
              32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0, 0};
        run(v);
        v = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, 0, 0, 1'b0, 32'h12345678,
              32'h300, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h12345678, 2};
        run(v);
        v = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h302, 32'h0, 1, 1, 1'b0, 32'h80017FFF,
              32'h300, 4'b1100, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 4};
        run(v);
        v = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h401, 32'h000000C3, 0, 0, 1'b0, 32'h0,
              32'h400, 4'b0010, 32'hC3C3C3C3, 1'b0, 1'b0, 32'h0, 2};
        run(v);
        v = '{1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h402, 32'h0, 0, 1, 1'b0, 32'h00AB0000,
              32'h400, 4'b0100, 32'h0, 1'b0, 1'b0, 32'hFFFFFFAB, 3};
        run(v);
        v = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h600, 32'h0, 0, 0, 1'b1, 32'h0,
              32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0, TMO + 1};
        run(v);
        v = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h700, 32'h11111111, 0, 0, 1'b0, 32'h0,
              32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0, 0};
        run(v);
        v = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h800, 32'hCAFEF00D, 2, 0, 1'b0, 32'h0,
              32'h800, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 4};
        run(v);
        v = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h500, 32'h0, 0, 0, 1'b0, 32'hFFFF9234,
              32'h500, 4'b0011, 32'h0, 1'b0, 1'b0, 32'h00009234, 2};
        run(v);

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(posedge clk);
        #1;
        mem_read     = 1'b1;
        mem_size     = SZ_WORD;
        mem_unsigned = 1'b0;
        addr         = 32'h900;
        write_data   = 32'h0;
        r.addr  = 32'h900;
        r.be    = 4'b1111;
        r.wdata = 32'h0;
        r.we    = 1'b0;
        req_q.push_back(r);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        bus_gnt  = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555AAAA;
        @(negedge clk);
        zero_outputs("midreset");
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_ignored", read_data, 32'h0);
        chk("late_rvalid_no_stall", {31'h0, stall}, 32'h0);

        v = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'hA00, 32'h0, 0, 1, 1'b0, 32'h0BADF00D,
              32'hA00, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 3};
        run(v);

        repeat (4) @(posedge clk);
        chk("req_queue_drained", req_q.size(), 32'h0);
        chk("rsp_queue_drained", rsp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
